turbo_encoder: RTL and testbench
================================

Name: turbo_encoder

Overview:
- Rate-1/3 parallel-concatenated convolutional (turbo) encoder; the transmit-side counterpart of the 54-bit→16-bit turbo decoder.
- Accepts a 16-bit information block and emits a 54-bit codeword:
  - systematic bits
  - RSC1 parity
  - RSC2 parity, computed over the QPP-interleaved block
  - RSC1 trellis-termination bits
- Bit-serial core: one trellis step per clock, valid/ready handshake on both sides.

Parameters:
- None. K=16, memory 3, and the 54-bit packing are fixed by the codeword format shared with the decoder.

Ports:
- clk_p_i  input  1  clock; all logic on the rising edge.
- reset_p_i  input  1  synchronous reset, active-high.
- valid_i  input  1  data_i holds a block.
- ready_o  output  1  encoder can accept a block.
- data_i  input  16  info bits; data_i[k] = x_k, k=0 encoded first.
- valid_o  output  1  data_o holds a complete codeword.
- ready_i  input  1  downstream accepts the codeword.
- data_o  output  54  codeword, packed as:
  - [15:0] x
  - [31:16] z (RSC1 parity)
  - [47:32] z' (RSC2 parity)
  - [50:48] xt (RSC1 tail systematic, bit 48 = t0)
  - [53:51] zt (RSC1 tail parity, bit 51 = t0)

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset state:
  - FSM=IDLE, ready_o=1, valid_o=0, data_o=0.
  - Both RSC state registers = 000, step counter = 0.
  - A reset sampled in any state aborts the block; nothing partial is emitted.
- RSC constituent code (identical for both encoders):
  - State (s1,s2,s3) holds the delays D, D^2, D^3.
  - Feedback a = x ^ s2 ^ s3 (g0 = 1+D^2+D^3).
  - Parity z = a ^ s1 ^ s3 (g1 = 1+D+D^3).
  - Update: s3<=s2, s2<=s1, s1<=a.
- Interleaver:
  - pi(i) = (3i + 4i^2) mod 16.
  - Table for i=0..15: 0,7,6,13,12,3,2,9,8,15,14,5,4,11,10,1.
  - RSC2 input at step i is x_pi(i), taken from the registered block.
- FSM states: IDLE → ENC → TAIL → OUT → IDLE.
  - IDLE: ready_o=1. On an edge where valid_i&&ready_o:
    - register data_i into the block register and data_o[15:0];
    - clear RSC states and the counter;
    - go to ENC.
  - ENC: ready_o=0. Each edge does step k = counter (0..15):
    - RSC1 encodes x_k; RSC2 encodes x_pi(k);
    - write z into data_o[16+k] and z' into data_o[32+k];
    - after step 15, go to TAIL with counter=0.
  - TAIL: 3 edges, t = 0..2, RSC1 only:
    - input x = s2^s3, forcing a=0;
    - xt_t = s2^s3, zt_t = s1^s3;
    - after t=2, RSC1 state is 000; go to OUT.
    - RSC2 is not terminated; its state is don't-care.
  - OUT: valid_o=1, data_o held stable.
    - On an edge with ready_i=1: valid_o<=0, go to IDLE.
    - ready_o returns high the cycle after that.
- Latency: valid_o rises 19 clocks after the accepting edge, i.e. 16 ENC + 3 TAIL.
- Throughput: at most one block per 21 clocks. There is no overlap between blocks.
- Boundary conditions:
  - valid_i while busy: ignored, since ready_o=0. The source must hold its block.
  - ready_i held high before OUT: no effect until valid_o=1. Transfer then happens on the first OUT edge.
  - ready_i low in OUT: hold indefinitely, data_o unchanged.
  - data_i changes after acceptance: no effect on the current block.
  - reset together with valid_i: reset wins; the block is not accepted.
- Stability: data_o is don't-care while valid_o=0, except that it is 0 after reset. The bench compares data_o only when valid_o=1.

Test Plan:
- Reset, then valid_i=1 with data_i=0x0000, ready_i=1 → valid_o=1 for exactly one cycle, 19 clocks after acceptance, with data_o=54'h0; ready_o=1 again on the next cycle.
- data_i=0x0001 → x=0x0001, z=0xA74F, z'=0xA74F, xt=3'b011, zt=3'b010.
- data_i=0x8000 → x=0x8000, z=0x8000, z'=0x9E00 (interleaved bit at i=9), xt=3'b110, zt=3'b101.
- ready_i=0 for 10 cycles once valid_o rises; toggle data_i and valid_i meanwhile → valid_o and data_o stay constant and ready_o stays 0; transfer occurs on the first edge with ready_i=1.
- Assert reset_p_i for 1 cycle during ENC step 7 → next cycle: valid_o=0, ready_o=1, data_o=0; a following 0x0001 block yields exactly the codeword from the 0x0001 test.
- 200 random blocks with random ready_i back-pressure, checked against the bench's golden encoder model → every codeword matches, and no codeword is lost or duplicated.

Source files
------------

// File: rtl/turbo_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : turbo_encoder
//  Brief    : Rate-1/3 bit-serial turbo encoder (K=16, two memory-3 RSCs,
//             QPP interleaver) producing the 54-bit decoder codeword.
//  Revision : 1.0
// ============================================================================
module turbo_encoder (
    input  logic        clk_p_i,
    input  logic        reset_p_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [53:0] data_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_TAIL = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_block;
    logic [3:0]  r_cnt;
    logic [2:0]  r_rsc1;    // [0]=s1 (D), [1]=s2 (D^2), [2]=s3 (D^3)
    logic [2:0]  r_rsc2;
    logic [53:0] r_data;

    logic [3:0]  w_pi;
    logic [5:0]  w_idx;
    logic        w_x1;
    logic        w_a1;
    logic        w_z1;
    logic        w_x2;
    logic        w_a2;
    logic        w_z2;

    // QPP interleaver pi(i) = (3i + 4i^2) mod 16
    always_comb begin
        w_pi = 4'd0;
        case (r_cnt)
            4'd0:  w_pi = 4'd0;
            4'd1:  w_pi = 4'd7;
            4'd2:  w_pi = 4'd6;
            4'd3:  w_pi = 4'd13;
            4'd4:  w_pi = 4'd12;
            4'd5:  w_pi = 4'd3;
            4'd6:  w_pi = 4'd2;
            4'd7:  w_pi = 4'd9;
            4'd8:  w_pi = 4'd8;
            4'd9:  w_pi = 4'd15;
            4'd10: w_pi = 4'd14;
            4'd11: w_pi = 4'd5;
            4'd12: w_pi = 4'd4;
            4'd13: w_pi = 4'd11;
            4'd14: w_pi = 4'd10;
            4'd15: w_pi = 4'd1;
            default: w_pi = 4'd0;
        endcase
    end

    // In TAIL the RSC1 input equals the feedback taps, which drives a to 0
    assign w_x1  = (r_state == ST_TAIL) ? (r_rsc1[1] ^ r_rsc1[2]) : r_block[r_cnt];
    assign w_a1  = w_x1 ^ r_rsc1[1] ^ r_rsc1[2];
    assign w_z1  = w_a1 ^ r_rsc1[0] ^ r_rsc1[2];
    assign w_x2  = r_block[w_pi];
    assign w_a2  = w_x2 ^ r_rsc2[1] ^ r_rsc2[2];
    assign w_z2  = w_a2 ^ r_rsc2[0] ^ r_rsc2[2];
    assign w_idx = {2'b00, r_cnt};

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (valid_i)          w_next = ST_ENC;
            ST_ENC:  if (r_cnt == 4'd15)   w_next = ST_TAIL;
            ST_TAIL: if (r_cnt == 4'd2)    w_next = ST_OUT;
            ST_OUT:  if (ready_i)          w_next = ST_IDLE;
            default:                       w_next = ST_IDLE;
        endcase
    end

    assign ready_o = (r_state == ST_IDLE);
    assign valid_o = (r_state == ST_OUT);
    assign data_o  = r_data;

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            r_block <= 16'd0;
            r_cnt   <= 4'd0;
            r_rsc1  <= 3'd0;
            r_rsc2  <= 3'd0;
            r_data  <= 54'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_block <= data_i;
                        r_data  <= {38'd0, data_i};
                        r_cnt   <= 4'd0;
                        r_rsc1  <= 3'd0;
                        r_rsc2  <= 3'd0;
                    end
                end
                ST_ENC: begin
                    r_rsc1                 <= {r_rsc1[1:0], w_a1};
                    r_rsc2                 <= {r_rsc2[1:0], w_a2};
                    r_data[6'd16 + w_idx]  <= w_z1;
                    r_data[6'd32 + w_idx]  <= w_z2;
                    r_cnt                  <= r_cnt + 4'd1;
                end
                ST_TAIL: begin
                    r_rsc1                 <= {r_rsc1[1:0], w_a1};
                    r_data[6'd48 + w_idx]  <= w_x1;
                    r_data[6'd51 + w_idx]  <= w_z1;
                    r_cnt                  <= (r_cnt == 4'd2) ? 4'd0 : r_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_turbo_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_turbo_encoder
//  Brief    : Self-checking bench for turbo_encoder against a sequence-level
//             golden model of the two RSC codes and the QPP interleaver.
//  Revision : 1.0
// ============================================================================
module tb_turbo_encoder;

    logic        clk_p_i;
    logic        reset_p_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [53:0] data_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    localparam logic [53:0] C_CW_0001 = {3'b010, 3'b011, 16'hA74F, 16'hA74F, 16'h0001};
    localparam logic [53:0] C_CW_8000 = {3'b101, 3'b110, 16'h9E00, 16'h8000, 16'h8000};

    turbo_encoder dut (
        .clk_p_i   (clk_p_i),
        .reset_p_i (reset_p_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o)
    );

    initial clk_p_i = 1'b0;
    always #5 clk_p_i = ~clk_p_i;

    // RSC as polynomial division: a[n] = u[n]^a[n-2]^a[n-3], z[n] = a[n]^a[n-1]^a[n-3]
    function automatic void rsc_model(input logic [15:0] u, output logic [15:0] z,
                                      output logic [2:0] xt, output logic [2:0] zt);
        bit a[22];
        for (int n = 0; n < 22; n++) a[n] = 1'b0;
        z = '0;
        for (int n = 0; n < 16; n++) begin
            a[n+3] = u[n] ^ a[n+1] ^ a[n];
            z[n]   = a[n+3] ^ a[n+2] ^ a[n];
        end
        for (int t = 0; t < 3; t++) begin
            xt[t]      = a[16+t+1] ^ a[16+t];
            a[16+t+3]  = 1'b0;
            zt[t]      = a[16+t+2] ^ a[16+t];
        end
    endfunction

    function automatic logic [53:0] golden(input logic [15:0] x);
        logic [15:0] z1, z2, u2;
        logic [2:0]  xt, zt, xt2, zt2;
        for (int i = 0; i < 16; i++) u2[i] = x[(3*i + 4*i*i) % 16];
        rsc_model(x,  z1, xt,  zt);
        rsc_model(u2, z2, xt2, zt2);
        return {zt, xt, z2, z1, x};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p_i);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int guard = 0;
        valid_i = 1'b1;
        data_i  = d;
        while (!ready_o && guard < 100) begin
            tick();
            guard++;
        end
        if (!ready_o) check("accept_timeout", 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0;
        data_i  = 16'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!valid_o && lat < 200) begin
            tick();
            lat++;
        end
        check("valid_seen", 64'(valid_o), 64'd1);
        check("latency", 64'(lat), 64'd19);
    endtask

    task automatic drain(input logic [53:0] exp, input int hold, input bit toggle);
        check("codeword", 64'(data_o), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            ready_i = 1'b0;
            if (toggle) begin
                valid_i = 1'($urandom);
                data_i  = 16'($urandom);
            end
            tick();
            check("hold_valid", 64'(valid_o), 64'd1);
            check("hold_data",  64'(data_o),  64'(exp));
            check("hold_ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        n_out++;
        check("post_valid", 64'(valid_o), 64'd0);
        check("post_ready", 64'(ready_o), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] d;
        reset_p_i = 1'b1;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        data_i    = 16'h0;
        repeat (3) tick();
        // reset and valid on the same edge: reset must win
        valid_i = 1'b1;
        data_i  = 16'h1234;
        tick();
        reset_p_i = 1'b0;
        valid_i   = 1'b0;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data",  64'(data_o),  64'd0);

        ready_i = 1'b1;
        send(16'h0000);
        wait_out(lat);
        drain(54'h0, 0, 1'b0);

        send(16'h0001);
        wait_out(lat);
        drain(C_CW_0001, 0, 1'b0);

        send(16'h8000);
        wait_out(lat);
        drain(C_CW_8000, 0, 1'b0);

        ready_i = 1'b0;
        send(16'h5A5A);
        wait_out(lat);
        drain(golden(16'h5A5A), 10, 1'b1);

        // abort in the middle of ENC (reset sampled at step 7)
        send(16'h0001);
        repeat (7) tick();
        reset_p_i = 1'b1;
        tick();
        reset_p_i = 1'b0;
        check("abort_valid", 64'(valid_o), 64'd0);
        check("abort_ready", 64'(ready_o), 64'd1);
        check("abort_data",  64'(data_o),  64'd0);
        send(16'h0001);
        wait_out(lat);
        drain(C_CW_0001, 0, 1'b0);

        n_out = 0;
        for (int b = 0; b < 200; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            d       = 16'($urandom);
            ready_i = 1'($urandom);
            send(d);
            wait_out(lat);
            drain(golden(d), $urandom_range(0, 4), 1'b0);
        end
        check("block_count", 64'(n_out), 64'd200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
